memory_game_ctrl: RTL and testbench



---
 rtl/memory_game_ctrl.sv | 169 ++++++++++++++++
 tb/tb_memory_game_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_game_ctrl.sv
// Turn controller for the memory-match board: sequences two picks per turn,
// compares the pair, locks or flips it back, alternates players and keeps
// scores. It is the single clocked owner of the face_up/matched board state.
module memory_game_ctrl #(
    parameter int N_CARDS     = 16,
    parameter int SHOW_CYCLES = 50_000_000,
    parameter int TURN_CYCLES = 750_000_000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   sel_valid,
    input  logic [3:0]             sel_idx,
    input  logic [3*N_CARDS-1:0]   card_vals,
    output logic                   sel_ready,
    output logic [N_CARDS-1:0]     face_up,
    output logic [N_CARDS-1:0]     matched,
    output logic                   player,
    output logic [3:0]             score0,
    output logic [3:0]             score1,
    output logic                   game_over,
    output logic                   timeout,
    output logic [2:0]             fsm_state
);

    // Handshake: a selection is a single-cycle sel_valid pulse; it is consumed
    // on the same edge only when sel_ready is high (PICK1/PICK2) and the card is
    // in range, not face-up and not matched. Anything else is dropped, never queued.

    localparam int CNT_MAX = (SHOW_CYCLES > TURN_CYCLES) ? SHOW_CYCLES : TURN_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] SHOW_LOAD = CNT_W'(SHOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PICK1   = 3'd1,
        PICK2   = 3'd2,
        COMPARE = 3'd3,
        SHOW    = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;       // shared: turn timer in PICK1/PICK2, show timer in SHOW
    logic [3:0]         idx_a;
    logic [3:0]         idx_b;

    logic [15:0]        busy_ext;
    logic               idx_in_range;
    logic               pick_ok;
    logic               pair_eq;
    logic               all_matched_next;
    logic [N_CARDS-1:0] bit_a;
    logic [N_CARDS-1:0] bit_b;
    logic [N_CARDS-1:0] bit_sel;

    // Pick legality, pair comparison and one-hot card masks
    always_comb begin
        busy_ext         = 16'(face_up | matched);
        idx_in_range     = ({1'b0, sel_idx} < 5'(N_CARDS));
        pick_ok          = sel_valid && ((state == PICK1) || (state == PICK2))
                           && idx_in_range && !busy_ext[sel_idx];
        pair_eq          = (card_vals[3*idx_a +: 3] == card_vals[3*idx_b +: 3]);
        bit_a            = N_CARDS'(1) << idx_a;
        bit_b            = N_CARDS'(1) << idx_b;
        bit_sel          = N_CARDS'(1) << sel_idx;
        all_matched_next = ((matched | bit_a | bit_b) == {N_CARDS{1'b1}});
    end

    // Moore decode of the pick window and state visibility
    always_comb begin
        sel_ready = (state == PICK1) || (state == PICK2);
        fsm_state = state;
    end

    // Turn sequencer, board state, scores and timers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx_a     <= '0;
            idx_b     <= '0;
            face_up   <= '0;
            matched   <= '0;
            player    <= 1'b0;
            score0    <= '0;
            score1    <= '0;
            game_over <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        face_up   <= '0;
                        matched   <= '0;
                        score0    <= '0;
                        score1    <= '0;
                        player    <= 1'b0;
                        game_over <= 1'b0;
                        cnt       <= TURN_LOAD;
                        state     <= PICK1;
                    end
                end
                PICK1: begin
                    if (pick_ok) begin
                        idx_a   <= sel_idx;
                        face_up <= face_up | bit_sel;
                        cnt     <= TURN_LOAD;
                        state   <= PICK2;
                    end else if (cnt == '0) begin
                        timeout <= 1'b1;
                        player  <= ~player;
                        cnt     <= TURN_LOAD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                PICK2: begin
                    if (pick_ok) begin
                        idx_b   <= sel_idx;
                        face_up <= face_up | bit_sel;
                        cnt     <= TURN_LOAD;
                        state   <= COMPARE;
                    end else if (cnt == '0) begin
                        // Expired half-turn: hide the lone first pick and hand over
                        timeout <= 1'b1;
                        face_up <= face_up & ~bit_a;
                        player  <= ~player;
                        cnt     <= TURN_LOAD;
                        state   <= PICK1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                COMPARE: begin
                    if (pair_eq) begin
                        matched <= matched | bit_a | bit_b;
                        if (player) score1 <= score1 + 4'd1;
                        else        score0 <= score0 + 4'd1;
                        if (all_matched_next) begin
                            game_over <= 1'b1;
                            state     <= DONE;
                        end else begin
                            cnt   <= TURN_LOAD;
                            state <= PICK1;
                        end
                    end else begin
                        cnt   <= SHOW_LOAD;
                        state <= SHOW;
                    end
                end
                SHOW: begin
                    if (cnt == '0) begin
                        face_up <= face_up & ~(bit_a | bit_b);
                        player  <= ~player;
                        cnt     <= TURN_LOAD;
                        state   <= PICK1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_game_ctrl.sv
// Directed bench for memory_game_ctrl with short show/turn timers.
module tb_memory_game_ctrl;

    localparam int SC = 4;
    localparam int TC = 10;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PICK1   = 3'd1;
    localparam logic [2:0] S_PICK2   = 3'd2;
    localparam logic [2:0] S_COMPARE = 3'd3;
    localparam logic [2:0] S_SHOW    = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        start_s;
    logic        sel_valid;
    logic [3:0]  sel_idx;
    logic [47:0] card_vals;
    logic [41:0] card_vals_s;

    logic        sel_ready;
    logic [15:0] face_up;
    logic [15:0] matched;
    logic        player;
    logic [3:0]  score0;
    logic [3:0]  score1;
    logic        game_over;
    logic        timeout;
    logic [2:0]  fsm_state;

    logic        sel_ready_s;
    logic [13:0] face_up_s;
    logic [13:0] matched_s;
    logic        player_s;
    logic [3:0]  score0_s;
    logic [3:0]  score1_s;
    logic        game_over_s;
    logic        timeout_s;
    logic [2:0]  fsm_state_s;

    int n_cmp  = 0;
    int n_fail = 0;

    memory_game_ctrl #(.N_CARDS(16), .SHOW_CYCLES(SC), .TURN_CYCLES(TC)) dut (
        .clk(clk), .rst(rst), .start(start), .sel_valid(sel_valid), .sel_idx(sel_idx),
        .card_vals(card_vals), .sel_ready(sel_ready), .face_up(face_up), .matched(matched),
        .player(player), .score0(score0), .score1(score1), .game_over(game_over),
        .timeout(timeout), .fsm_state(fsm_state)
    );

    memory_game_ctrl #(.N_CARDS(14), .SHOW_CYCLES(SC), .TURN_CYCLES(TC)) dut_small (
        .clk(clk), .rst(rst), .start(start_s), .sel_valid(sel_valid), .sel_idx(sel_idx),
        .card_vals(card_vals_s), .sel_ready(sel_ready_s), .face_up(face_up_s),
        .matched(matched_s), .player(player_s), .score0(score0_s), .score1(score1_s),
        .game_over(game_over_s), .timeout(timeout_s), .fsm_state(fsm_state_s)
    );

    // Clock
    always #5 clk = ~clk;

    // Driver tasks: all start and end just after a falling edge
    task automatic step();
        @(negedge clk);
    endtask

    task automatic pick(input int i);
        sel_valid = 1'b1;
        sel_idx   = 4'(i);
        step();
        sel_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_match(input int a, input int b);
        pick(a);
        pick(b);
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start_s = 1'b0; sel_valid = 1'b0; sel_idx = 4'd0;
        repeat (3) step();
        n_cmp++;
        if ({face_up, matched, player, score0, score1, game_over, timeout, sel_ready, fsm_state} !== 47'd0) begin
            n_fail++;
            $display("FAIL reset_hold: fu=%h m=%h p=%b s0=%0d s1=%0d go=%b to=%b rdy=%b st=%0d, want all 0",
                     face_up, matched, player, score0, score1, game_over, timeout, sel_ready, fsm_state);
        end
        rst = 1'b0;
        step();
        n_cmp++;
        if ({face_up, matched, player, score0, score1, game_over, timeout, sel_ready, fsm_state} !== 47'd0) begin
            n_fail++;
            $display("FAIL reset_release: fu=%h st=%0d rdy=%b, want all 0", face_up, fsm_state, sel_ready);
        end
    endtask

    task automatic test_out_of_range();
        start_s = 1'b1;
        step();
        start_s = 1'b0;
        n_cmp++;
        if (fsm_state_s !== S_PICK1) begin
            n_fail++; $display("FAIL small_start: st=%0d want %0d", fsm_state_s, S_PICK1);
        end
        pick(15);
        pick(14);
        n_cmp++;
        if ({face_up_s, fsm_state_s} !== {14'h0000, S_PICK1}) begin
            n_fail++; $display("FAIL small_oob: fu=%h st=%0d want 0000/%0d", face_up_s, fsm_state_s, S_PICK1);
        end
        pick(13);
        n_cmp++;
        if ({face_up_s, fsm_state_s} !== {14'h2000, S_PICK2}) begin
            n_fail++; $display("FAIL small_last: fu=%h st=%0d want 2000/%0d", face_up_s, fsm_state_s, S_PICK2);
        end
        n_cmp++;
        if ({face_up, fsm_state} !== {16'h0000, S_IDLE}) begin
            n_fail++; $display("FAIL idle_drop: fu=%h st=%0d want 0000/%0d", face_up, fsm_state, S_IDLE);
        end
    endtask

    task automatic test_match();
        pulse_start();
        n_cmp++;
        if ({fsm_state, sel_ready, player} !== {S_PICK1, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL start: st=%0d rdy=%b p=%b want %0d/1/0", fsm_state, sel_ready, player, S_PICK1);
        end
        pick(0);
        n_cmp++;
        if ({face_up, fsm_state} !== {16'h0001, S_PICK2}) begin
            n_fail++; $display("FAIL pick1: fu=%h st=%0d want 0001/%0d", face_up, fsm_state, S_PICK2);
        end
        pick(1);
        n_cmp++;
        if ({face_up, matched, fsm_state, sel_ready} !== {16'h0003, 16'h0000, S_COMPARE, 1'b0}) begin
            n_fail++; $display("FAIL compare: fu=%h m=%h st=%0d rdy=%b want 0003/0000/%0d/0",
                               face_up, matched, fsm_state, sel_ready, S_COMPARE);
        end
        step();
        n_cmp++;
        if ({matched, score0, player, sel_ready, fsm_state} !== {16'h0003, 4'd1, 1'b0, 1'b1, S_PICK1}) begin
            n_fail++; $display("FAIL match: m=%h s0=%0d p=%b rdy=%b st=%0d want 0003/1/0/1/%0d",
                               matched, score0, player, sel_ready, fsm_state, S_PICK1);
        end
    endtask

    task automatic test_mismatch();
        pick(2);
        pick(4);
        n_cmp++;
        if ({face_up, fsm_state} !== {16'h0017, S_COMPARE}) begin
            n_fail++; $display("FAIL mm_compare: fu=%h st=%0d want 0017/%0d", face_up, fsm_state, S_COMPARE);
        end
        step();
        for (int k = 0; k < SC; k++) begin
            n_cmp++;
            if ({face_up, fsm_state, player} !== {16'h0017, S_SHOW, 1'b0}) begin
                n_fail++; $display("FAIL show_hold[%0d]: fu=%h st=%0d p=%b want 0017/%0d/0",
                                   k, face_up, fsm_state, player, S_SHOW);
            end
            step();
        end
        n_cmp++;
        if ({face_up, player, score0, score1, fsm_state} !== {16'h0003, 1'b1, 4'd1, 4'd0, S_PICK1}) begin
            n_fail++; $display("FAIL flip_back: fu=%h p=%b s0=%0d s1=%0d st=%0d want 0003/1/1/0/%0d",
                               face_up, player, score0, score1, fsm_state, S_PICK1);
        end
    endtask

    task automatic test_illegal();
        pick(3);
        pick(3);
        pick(0);
        n_cmp++;
        if ({face_up, matched, fsm_state} !== {16'h000B, 16'h0003, S_PICK2}) begin
            n_fail++; $display("FAIL illegal: fu=%h m=%h st=%0d want 000b/0003/%0d",
                               face_up, matched, fsm_state, S_PICK2);
        end
        pick(5);
        step();
        pick(6);
        n_cmp++;
        if ({face_up, fsm_state} !== {16'h002B, S_SHOW}) begin
            n_fail++; $display("FAIL show_drop: fu=%h st=%0d want 002b/%0d", face_up, fsm_state, S_SHOW);
        end
        repeat (3) step();
        n_cmp++;
        if ({face_up, player, fsm_state} !== {16'h0003, 1'b0, S_PICK1}) begin
            n_fail++; $display("FAIL illegal_end: fu=%h p=%b st=%0d want 0003/0/%0d",
                               face_up, player, fsm_state, S_PICK1);
        end
    endtask

    task automatic test_timeout();
        pick(4);
        repeat (TC - 1) step();
        n_cmp++;
        if ({timeout, face_up, fsm_state} !== {1'b0, 16'h0013, S_PICK2}) begin
            n_fail++; $display("FAIL pre_expiry: to=%b fu=%h st=%0d want 0/0013/%0d",
                               timeout, face_up, fsm_state, S_PICK2);
        end
        step();
        n_cmp++;
        if ({timeout, face_up, player, fsm_state} !== {1'b1, 16'h0003, 1'b1, S_PICK1}) begin
            n_fail++; $display("FAIL expiry: to=%b fu=%h p=%b st=%0d want 1/0003/1/%0d",
                               timeout, face_up, player, fsm_state, S_PICK1);
        end
        step();
        n_cmp++;
        if (timeout !== 1'b0) begin
            n_fail++; $display("FAIL to_pulse: to=%b want 0", timeout);
        end
        repeat (TC - 2) step();
        pick(4);
        n_cmp++;
        if ({timeout, face_up, fsm_state, player} !== {1'b0, 16'h0013, S_PICK2, 1'b1}) begin
            n_fail++; $display("FAIL pick_wins: to=%b fu=%h st=%0d p=%b want 0/0013/%0d/1",
                               timeout, face_up, fsm_state, player, S_PICK2);
        end
        pick(5);
        step();
        n_cmp++;
        if ({matched, score1, player, timeout} !== {16'h0033, 4'd1, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL p1_match: m=%h s1=%0d p=%b to=%b want 0033/1/1/0",
                               matched, score1, player, timeout);
        end
    endtask

    task automatic test_full_game();
        do_match(2, 3);
        pick(6);
        pick(8);
        step();
        pick(9);
        repeat (3) step();
        n_cmp++;
        if ({face_up, player, score1, fsm_state} !== {16'h003F, 1'b0, 4'd2, S_PICK1}) begin
            n_fail++; $display("FAIL game_mid: fu=%h p=%b s1=%0d st=%0d want 003f/0/2/%0d",
                               face_up, player, score1, fsm_state, S_PICK1);
        end
        do_match(6, 7);
        do_match(8, 9);
        do_match(10, 11);
        pick(12);
        pick(14);
        repeat (SC + 1) step();
        n_cmp++;
        if ({matched, score0, player} !== {16'h0FFF, 4'd4, 1'b1}) begin
            n_fail++; $display("FAIL game_p0: m=%h s0=%0d p=%b want 0fff/4/1", matched, score0, player);
        end
        do_match(12, 13);
        do_match(14, 15);
        n_cmp++;
        if ({game_over, fsm_state, matched, face_up, score0, score1, sel_ready}
            !== {1'b1, S_DONE, 16'hFFFF, 16'hFFFF, 4'd4, 4'd4, 1'b0}) begin
            n_fail++; $display("FAIL game_over: go=%b st=%0d m=%h fu=%h s0=%0d s1=%0d rdy=%b want 1/%0d/ffff/ffff/4/4/0",
                               game_over, fsm_state, matched, face_up, score0, score1, sel_ready, S_DONE);
        end
        pick(0);
        repeat (TC + 2) step();
        n_cmp++;
        if ({game_over, fsm_state, matched, score1} !== {1'b1, S_DONE, 16'hFFFF, 4'd4}) begin
            n_fail++; $display("FAIL done_hold: go=%b st=%0d m=%h s1=%0d want 1/%0d/ffff/4",
                               game_over, fsm_state, matched, score1, S_DONE);
        end
        pulse_start();
        n_cmp++;
        if ({face_up, matched, score0, score1, player, game_over, fsm_state}
            !== {16'h0, 16'h0, 4'd0, 4'd0, 1'b0, 1'b0, S_PICK1}) begin
            n_fail++; $display("FAIL restart: fu=%h m=%h s0=%0d s1=%0d p=%b go=%b st=%0d want clear/%0d",
                               face_up, matched, score0, score1, player, game_over, fsm_state, S_PICK1);
        end
    endtask

    task automatic test_reset_mid();
        pick(0);
        pick(2);
        step();
        step();
        n_cmp++;
        if (fsm_state !== S_SHOW) begin
            n_fail++; $display("FAIL pre_rst: st=%0d want %0d", fsm_state, S_SHOW);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({face_up, matched, player, score0, score1, game_over, timeout, sel_ready, fsm_state} !== 47'd0) begin
            n_fail++; $display("FAIL async_rst: fu=%h m=%h p=%b st=%0d, want all 0",
                               face_up, matched, player, fsm_state);
        end
        step();
        rst = 1'b0;
        step();
        pulse_start();
        do_match(0, 1);
        n_cmp++;
        if ({face_up, matched, score0, score1, player, fsm_state}
            !== {16'h0003, 16'h0003, 4'd1, 4'd0, 1'b0, S_PICK1}) begin
            n_fail++; $display("FAIL clean_game: fu=%h m=%h s0=%0d s1=%0d p=%b st=%0d want 0003/0003/1/0/0/%0d",
                               face_up, matched, score0, score1, player, fsm_state, S_PICK1);
        end
    endtask

    // Card i holds pair ID i/2
    initial begin
        for (int i = 0; i < 16; i++) card_vals[3*i +: 3] = 3'(i / 2);
        for (int i = 0; i < 14; i++) card_vals_s[3*i +: 3] = 3'(i / 2);
    end

    // Test sequence and report
    initial begin
        test_reset();
        test_out_of_range();
        test_match();
        test_mismatch();
        test_illegal();
        test_timeout();
        test_full_game();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Run-time bound
    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: sim time %0t exceeded bound", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
